dbus_pair_arbiter: RTL and testbench
====================================

# dbus_pair_arbiter

Serialises the two physical data-bus requests produced each cycle by the MMU (dual-issue memory slots 0 and 1, already translated, each tagged cached/uncached) onto two downstream buses: the D-cache bus and the uncached bus. Sits directly downstream of the address-translation stage and upstream of the D-cache and the uncached AXI bridge. Returns one joined completion to the pipeline when every valid slot has finished, preserving program order (slot 0 before slot 1) on any shared bus.

## Interface
- No parameters; all widths come from the shared `dbus_req_t` / `dbus_resp_t` types.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `dreq` in 2×`dbus_req_t`: translated requests {valid, addr[31:0], size[2:0], strobe[3:0], data[31:0]}; held stable by the pipeline until completion.
- `d_uncache` in 2: per-slot uncached flag from the MMU.
- `dresp` out 2×`dbus_resp_t`: {addr_ok, data_ok, data[31:0]} back to the pipeline.
- `dcreq` out `dbus_req_t`: request to the D-cache.
- `dcresp` in `dbus_resp_t`: D-cache response.
- `ucreq` out `dbus_req_t`: request to the uncached bridge.
- `ucresp` in `dbus_resp_t`: uncached bridge response.

## Operation
- Two identical per-slot trackers, each with phase IDLE → REQ → WAIT → DONE.
- **Accept:** both trackers IDLE and any `dreq[i].valid`.
  - Latch both requests and both `d_uncache` bits.
  - Each valid slot leaves IDLE; invalid slots stay IDLE and count as finished.
- **Bus select:** slot i uses `ucreq` if its latched uncache bit is set, else `dcreq`.
- **Ordering:**
  - Slot 1 may enter REQ only when slot 0 is DONE or invalid.
  - Exception: parallel issue, see Configuration.
- **REQ:** drive the latched request with valid=1 on the selected bus.
  - On addr_ok without data_ok, go to WAIT.
  - On addr_ok with data_ok in the same cycle, go straight to DONE and capture data.
- **WAIT:** on data_ok of the selected bus, capture `data` into the slot buffer and go to DONE.
- **Join:** in a cycle where every valid slot is DONE, drive `dresp[i].addr_ok` = `dresp[i].data_ok` = 1 for each valid slot, with its buffered data. All trackers return to IDLE the next cycle.
- **Idle outputs:**
  - A bus with no tracker in REQ has valid=0.
  - `dresp` outputs are 0 except in the join cycle.
- **Arbitration:** if both trackers would drive the same bus, slot 0 wins. By construction this occurs only in illegal states; assert it in simulation.
- **Stores:** data_ok completes the slot; the captured data is don't-care and still forwarded.
- **Reset:** synchronous reset clears all trackers to IDLE and zeroes the buffers.
  - Reset mid-transaction abandons the in-flight transaction; downstream buses are reset in the same cycle.
  - All outputs are 0 after reset: `dcreq.valid`, `ucreq.valid`, and all `dresp` fields.

## Timing
- **Cycle T:** accept with `dreq` valid. **T+1:** first bus request visible, at the earliest.
- **Minimum single-slot latency:** addr_ok and data_ok both at T+1, slot DONE at T+2, join (`data_ok`) at T+2. Two cycles from accept.
- **Serial two-slot, zero-wait buses:** slot 0 DONE at T+2, slot 1 REQ at T+2, slot 1 DONE at T+3, join at T+3.
- **Back-to-back operations:** join at cycle C, IDLE at C+1, next accept possible at C+1.
- **Held valid:** a `dreq` still valid in the join cycle is not re-accepted, because the trackers are not IDLE.
- **Timing discipline:** bus valid is registered phase state; no combinational path from `dcresp`/`ucresp` to `dcreq`/`ucreq`. `dresp` is decoded from registered state only.

## Configuration
- **`DBUS_PARALLEL_ISSUE_EN` defined:** when both slots are valid and target different buses, slot 1 enters REQ in the same cycle as slot 0. Same-bus pairs remain serial.
- **Undefined:** always serial, slot 0 then slot 1.
- Join semantics are identical in both builds.

## Structure
- Shared package `dbus_arb_pkg` holds:
  - `dbus_slot_phase_t` (IDLE/REQ/WAIT/DONE, 2-bit enum).
  - `dbus_slot_state_t` (phase, latched req, uncache bit, data buffer).
  - Bus-select constants.
- One sub-module `dbus_slot_tracker`, instantiated twice, with ports:
  - inputs: start, may_issue, sel response;
  - outputs: phase, bus req, buffered data.
- Top level contains accept logic, the ordering gate, the bus muxes and the join decode.

## Test plan
- **Single cached load:** slot 0 addr 0x0000_1000, cache returns addr_ok and data_ok at T+1 with data 0xDEAD_BEEF → `dresp[0].data_ok` at T+2, data 0xDEAD_BEEF; `dresp[1]` stays 0.
- **Two cached slots:** cache addr_ok/data_ok delayed 3 cycles each → slot 1's `dcreq` never asserts before slot 0 DONE; single join asserts both `data_ok` with respective data.
- **Slot 0 uncached store, slot 1 cached load:**
  - Without the macro: `ucreq` then `dcreq`, sequentially.
  - With `DBUS_PARALLEL_ISSUE_EN`: both valid at T+1, join after the later data_ok.
- **Slot 0 invalid, slot 1 uncached load:** `ucreq` at T+1; join drives only `dresp[1]`.
- **Reset mid-operation:** `resetn`=0 while slot 0 is in WAIT → next cycle all outputs 0 and trackers IDLE; a new request after release completes normally.
- **Back-to-back:** new `dreq` pair presented at C+1 after join → accepted at C+1, bus request at C+2, no duplicated completion.

Source files
------------

// File: rtl/dbus_pair_arbiter_pkg.sv
// dbus_arb_pkg: types and constants shared by the dual-slot data-bus arbiter.
//   dbus_req_t        : translated request {valid, addr, size, strobe, data}
//   dbus_resp_t       : bus response {addr_ok, data_ok, data}
//   dbus_slot_phase_t : per-slot tracker phase (IDLE/REQ/WAIT/DONE)
//   dbus_slot_state_t : full per-slot tracker state
//   BUS_SEL_*         : value of a slot's latched uncache bit selecting its bus
package dbus_arb_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_REQ  = 2'd1,
        PH_WAIT = 2'd2,
        PH_DONE = 2'd3
    } dbus_slot_phase_t;

    typedef struct packed {
        dbus_slot_phase_t phase;
        dbus_req_t        req;
        logic             uncache;
        logic [31:0]      data_buf;
    } dbus_slot_state_t;

    localparam logic BUS_SEL_DCACHE   = 1'b0;
    localparam logic BUS_SEL_UNCACHED = 1'b1;

endpackage

// File: rtl/dbus_pair_arbiter_if.sv
// dbus_pair_arbiter_if: bundle of the pipeline-side and downstream bus signals.
//   dreq/d_uncache : two translated requests and their uncached flags
//   dresp          : joined completion back to the pipeline
//   dcreq/dcresp   : D-cache bus
//   ucreq/ucresp   : uncached bridge bus
// Handshake: a bus request is offered while req.valid=1; the target accepts the
// address with addr_ok and completes the access with data_ok (possibly in the
// same cycle as addr_ok). The requester holds the request stable until addr_ok.
// modport slave  : the arbiter's view; modport master : the environment's view.
interface dbus_pair_arbiter_if;
    import dbus_arb_pkg::*;

    dbus_req_t  [1:0] dreq;
    logic       [1:0] d_uncache;
    dbus_resp_t [1:0] dresp;
    dbus_req_t        dcreq;
    dbus_resp_t       dcresp;
    dbus_req_t        ucreq;
    dbus_resp_t       ucresp;

    modport slave  (input  dreq, d_uncache, dcresp, ucresp,
                    output dresp, dcreq, ucreq);
    modport master (output dreq, d_uncache, dcresp, ucresp,
                    input  dresp, dcreq, ucreq);
endinterface

// File: rtl/dbus_slot_tracker.sv
// dbus_slot_tracker: follows one memory slot through IDLE -> REQ -> WAIT -> DONE.
//   start     : accept pulse; latches req_in/uncache_in (slot leaves IDLE if valid)
//   may_issue : ordering gate; the request is only offered on the bus while high
//   clear     : join cycle; DONE returns to IDLE
//   sel_resp  : response of the bus this slot selected
//   phase     : current phase (also the debug view of the FSM)
//   valid     : latched request valid (an invalid slot counts as finished)
//   uncache   : latched bus select
//   bus_req   : request to place on the selected bus
//   data_buf  : data captured on data_ok
module dbus_slot_tracker
    import dbus_arb_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  dbus_req_t        req_in,
    input  logic             uncache_in,
    input  logic             may_issue,
    input  logic             clear,
    input  dbus_resp_t       sel_resp,
    output dbus_slot_phase_t phase,
    output logic             valid,
    output logic             uncache,
    output dbus_req_t        bus_req,
    output logic [31:0]      data_buf
);

    dbus_slot_state_t st_q, st_d;

    always_ff @(posedge clk) begin
        if (!resetn) st_q <= '0;
        else         st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q.phase)
            PH_IDLE: begin
                if (start) begin
                    st_d.req     = req_in;
                    st_d.uncache = uncache_in;
                    if (req_in.valid) st_d.phase = PH_REQ;
                end
            end
            PH_REQ: begin
                // Responses only count while this slot actually owns the bus.
                if (may_issue && sel_resp.addr_ok) begin
                    if (sel_resp.data_ok) begin
                        st_d.phase    = PH_DONE;
                        st_d.data_buf = sel_resp.data;
                    end else begin
                        st_d.phase = PH_WAIT;
                    end
                end
            end
            PH_WAIT: begin
                if (sel_resp.data_ok) begin
                    st_d.phase    = PH_DONE;
                    st_d.data_buf = sel_resp.data;
                end
            end
            PH_DONE: begin
                if (clear) begin
                    st_d.phase     = PH_IDLE;
                    st_d.req.valid = 1'b0;
                end
            end
            default: st_d.phase = PH_IDLE;
        endcase
    end

    // may_issue is built from registered state only, so bus valid never
    // depends combinationally on a bus response.
    always_comb begin
        phase         = st_q.phase;
        valid         = st_q.req.valid;
        uncache       = st_q.uncache;
        data_buf      = st_q.data_buf;
        bus_req       = st_q.req;
        bus_req.valid = (st_q.phase == PH_REQ) && may_issue;
    end

endmodule

// File: rtl/dbus_pair_arbiter.sv
// dbus_pair_arbiter: serialises the two per-cycle MMU data requests onto the
// D-cache bus and the uncached bus and returns one joined completion.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : dbus_pair_arbiter_if.slave (dreq, d_uncache, dresp,
//                 dcreq, dcresp, ucreq, ucresp)
//   dbg_phase   : phase of each slot tracker
// Build option: DBUS_PARALLEL_ISSUE_EN lets slot 1 issue alongside slot 0 when
// the two slots target different buses; otherwise slot 1 waits for slot 0.
module dbus_pair_arbiter
    import dbus_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    dbus_pair_arbiter_if.slave     bus,
    output dbus_slot_phase_t [1:0] dbg_phase
);

    dbus_slot_phase_t phase     [2];
    logic             valid     [2];
    logic             unc       [2];
    logic             may_issue [2];
    dbus_req_t        breq      [2];
    dbus_resp_t       sel_resp  [2];
    logic [31:0]      dbuf      [2];

    logic accept, fin0, fin1, busy, join_now, dc_conflict, uc_conflict;

    assign accept = (phase[0] == PH_IDLE) && (phase[1] == PH_IDLE) &&
                    (bus.dreq[0].valid || bus.dreq[1].valid);

    assign fin0     = !valid[0] || (phase[0] == PH_DONE);
    assign fin1     = !valid[1] || (phase[1] == PH_DONE);
    assign busy     = (phase[0] != PH_IDLE) || (phase[1] != PH_IDLE);
    assign join_now = busy && fin0 && fin1;

    assign may_issue[0] = 1'b1;
`ifdef DBUS_PARALLEL_ISSUE_EN
    assign may_issue[1] = fin0 || (valid[0] && valid[1] && (unc[0] != unc[1]));
`else
    assign may_issue[1] = fin0;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++)
            sel_resp[i] = (unc[i] == BUS_SEL_UNCACHED) ? bus.ucresp : bus.dcresp;
    end

    dbus_slot_tracker u_slot0 (
        .clk(clk), .resetn(resetn), .start(accept),
        .req_in(bus.dreq[0]), .uncache_in(bus.d_uncache[0]),
        .may_issue(may_issue[0]), .clear(join_now), .sel_resp(sel_resp[0]),
        .phase(phase[0]), .valid(valid[0]), .uncache(unc[0]),
        .bus_req(breq[0]), .data_buf(dbuf[0])
    );

    dbus_slot_tracker u_slot1 (
        .clk(clk), .resetn(resetn), .start(accept),
        .req_in(bus.dreq[1]), .uncache_in(bus.d_uncache[1]),
        .may_issue(may_issue[1]), .clear(join_now), .sel_resp(sel_resp[1]),
        .phase(phase[1]), .valid(valid[1]), .uncache(unc[1]),
        .bus_req(breq[1]), .data_buf(dbuf[1])
    );

    // Slot 0 is written last so it wins a (never expected) same-bus collision.
    always_comb begin
        bus.dcreq = '0;
        bus.ucreq = '0;
        if (breq[1].valid) begin
            if (unc[1] == BUS_SEL_UNCACHED) bus.ucreq = breq[1];
            else                            bus.dcreq = breq[1];
        end
        if (breq[0].valid) begin
            if (unc[0] == BUS_SEL_UNCACHED) bus.ucreq = breq[0];
            else                            bus.dcreq = breq[0];
        end
    end

    assign dc_conflict = breq[0].valid && breq[1].valid &&
                         (unc[0] == BUS_SEL_DCACHE) && (unc[1] == BUS_SEL_DCACHE);
    assign uc_conflict = breq[0].valid && breq[1].valid &&
                         (unc[0] == BUS_SEL_UNCACHED) && (unc[1] == BUS_SEL_UNCACHED);

    always_ff @(posedge clk) begin
        if (resetn) assert (!(dc_conflict || uc_conflict));
    end

    always_comb begin
        bus.dresp = '0;
        if (join_now) begin
            for (int i = 0; i < 2; i++) begin
                if (valid[i]) begin
                    bus.dresp[i].addr_ok = 1'b1;
                    bus.dresp[i].data_ok = 1'b1;
                    bus.dresp[i].data    = dbuf[i];
                end
            end
        end
    end

    assign dbg_phase[0] = phase[0];
    assign dbg_phase[1] = phase[1];

endmodule

// File: tb/tb_dbus_pair_arbiter.sv
// tb_dbus_pair_arbiter: directed and randomized checks of dbus_pair_arbiter.
// Bus responders return D-cache data addr ^ 32'hDEAD_AEEF and uncached data
// ~addr after per-slot address/data delays chosen by each step.
module tb_dbus_pair_arbiter;
    import dbus_arb_pkg::*;

`ifdef DBUS_PARALLEL_ISSUE_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    dbus_slot_phase_t [1:0] dbg_phase;

    dbus_pair_arbiter_if bus_if ();

    dbus_pair_arbiter dut (
        .clk(clk), .resetn(resetn), .bus(bus_if.slave), .dbg_phase(dbg_phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cur_addr0, cur_addr1;
    int a_dly0, d_dly0, a_dly1, d_dly1;

    function automatic logic [31:0] dc_data(input logic [31:0] a);
        return a ^ 32'hDEAD_AEEF;
    endfunction

    function automatic logic [31:0] uc_data(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- bus responders ----------------
    int dc_st = 0, dc_cnt = 0, dc_dd = 0, dc_ad = 0, dc_d = 0;
    logic [31:0] dc_addr;
    always @(negedge clk) begin
        bus_if.dcresp = '0;
        if (!resetn) begin
            dc_st = 0; dc_cnt = 0;
        end else if (dc_st == 0) begin
            if (bus_if.dcreq.valid) begin
                if (bus_if.dcreq.addr == cur_addr0) begin dc_ad = a_dly0; dc_d = d_dly0; end
                else begin dc_ad = a_dly1; dc_d = d_dly1; end
                if (dc_cnt >= dc_ad) begin
                    bus_if.dcresp.addr_ok = 1'b1;
                    dc_cnt = 0;
                    if (dc_d == 0) begin
                        bus_if.dcresp.data_ok = 1'b1;
                        bus_if.dcresp.data    = dc_data(bus_if.dcreq.addr);
                    end else begin
                        dc_st = 1; dc_dd = dc_d; dc_addr = bus_if.dcreq.addr;
                    end
                end else dc_cnt++;
            end
        end else begin
            dc_cnt++;
            if (dc_cnt >= dc_dd) begin
                bus_if.dcresp.data_ok = 1'b1;
                bus_if.dcresp.data    = dc_data(dc_addr);
                dc_st = 0; dc_cnt = 0;
            end
        end
    end

    int uc_st = 0, uc_cnt = 0, uc_dd = 0, uc_ad = 0, uc_d = 0;
    logic [31:0] uc_addr;
    always @(negedge clk) begin
        bus_if.ucresp = '0;
        if (!resetn) begin
            uc_st = 0; uc_cnt = 0;
        end else if (uc_st == 0) begin
            if (bus_if.ucreq.valid) begin
                if (bus_if.ucreq.addr == cur_addr0) begin uc_ad = a_dly0; uc_d = d_dly0; end
                else begin uc_ad = a_dly1; uc_d = d_dly1; end
                if (uc_cnt >= uc_ad) begin
                    bus_if.ucresp.addr_ok = 1'b1;
                    uc_cnt = 0;
                    if (uc_d == 0) begin
                        bus_if.ucresp.data_ok = 1'b1;
                        bus_if.ucresp.data    = uc_data(bus_if.ucreq.addr);
                    end else begin
                        uc_st = 1; uc_dd = uc_d; uc_addr = bus_if.ucreq.addr;
                    end
                end else uc_cnt++;
            end
        end else begin
            uc_cnt++;
            if (uc_cnt >= uc_dd) begin
                bus_if.ucresp.data_ok = 1'b1;
                bus_if.ucresp.data    = uc_data(uc_addr);
                uc_st = 0; uc_cnt = 0;
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic clear_dreq();
        bus_if.dreq      = '0;
        bus_if.d_uncache = 2'b00;
    endtask

    // b2b: the pair is presented in the join cycle of the previous operation.
    task automatic run_op(input bit b2b, input bit v0, input bit v1,
                          input bit u0, input bit u1,
                          input int a0, input int d0, input int a1, input int d1,
                          input logic [31:0] ad0, input logic [31:0] ad1,
                          input bit st0, input bit st1);
        bit par;
        int base, s0, s1, done0, done1, jn;
        bit in0, in1, exp_dc, exp_uc;
        dbus_resp_t exp_r0, exp_r1;
        par   = v0 && v1 && (u0 != u1) && PAR_EN;
        base  = b2b ? 1 : 0;
        s0    = base + 1;
        done0 = s0 + a0 + d0 + 1;
        s1    = (!v0 || par) ? base + 1 : done0;
        done1 = s1 + a1 + d1 + 1;
        jn    = 0;
        if (v0 && done0 > jn) jn = done0;
        if (v1 && done1 > jn) jn = done1;
        exp_r0 = '0;
        exp_r1 = '0;
        if (v0) exp_r0 = '{addr_ok: 1'b1, data_ok: 1'b1, data: u0 ? uc_data(ad0) : dc_data(ad0)};
        if (v1) exp_r1 = '{addr_ok: 1'b1, data_ok: 1'b1, data: u1 ? uc_data(ad1) : dc_data(ad1)};

        if (!b2b) begin
            clear_dreq();
            @(negedge clk);
        end
        cur_addr0 = ad0; cur_addr1 = ad1;
        a_dly0 = a0; d_dly0 = d0; a_dly1 = a1; d_dly1 = d1;
        bus_if.dreq[0] = '{valid: v0, addr: ad0, size: 3'd2,
                           strobe: st0 ? 4'hF : 4'h0, data: ad0 + 32'd1};
        bus_if.dreq[1] = '{valid: v1, addr: ad1, size: 3'd2,
                           strobe: st1 ? 4'hF : 4'h0, data: ad1 + 32'd1};
        bus_if.d_uncache = {u1, u0};

        for (int n = 1; n <= jn; n++) begin
            @(posedge clk); #1;
            in0 = v0 && (n >= s0) && (n <= s0 + a0);
            in1 = v1 && (n >= s1) && (n <= s1 + a1);
            exp_dc = (in0 && !u0) || (in1 && !u1);
            exp_uc = (in0 && u0) || (in1 && u1);
            chk("dcreq_valid", 64'(bus_if.dcreq.valid), 64'(exp_dc));
            if (exp_dc) chk("dcreq_addr", 64'(bus_if.dcreq.addr), 64'((in0 && !u0) ? ad0 : ad1));
            chk("ucreq_valid", 64'(bus_if.ucreq.valid), 64'(exp_uc));
            if (exp_uc) chk("ucreq_addr", 64'(bus_if.ucreq.addr), 64'((in0 && u0) ? ad0 : ad1));
            if (n == jn) begin
                chk("join_dresp0", 64'(bus_if.dresp[0]), 64'(exp_r0));
                chk("join_dresp1", 64'(bus_if.dresp[1]), 64'(exp_r1));
            end else begin
                chk("idle_dresp0", 64'(bus_if.dresp[0]), 64'd0);
                chk("idle_dresp1", 64'(bus_if.dresp[1]), 64'd0);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rv0, rv1, ru0, ru1, rb;
        int vv;
        logic [31:0] ra;
        clear_dreq();
        cur_addr0 = '0; cur_addr1 = '0;
        a_dly0 = 0; d_dly0 = 0; a_dly1 = 0; d_dly1 = 0;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dcreq_valid", 64'(bus_if.dcreq.valid), 64'd0);
        chk("rst_ucreq_valid", 64'(bus_if.ucreq.valid), 64'd0);
        chk("rst_dresp0", 64'(bus_if.dresp[0]), 64'd0);
        chk("rst_dresp1", 64'(bus_if.dresp[1]), 64'd0);
        chk("rst_phase0", 64'(dbg_phase[0]), 64'(PH_IDLE));
        chk("rst_phase1", 64'(dbg_phase[1]), 64'(PH_IDLE));
        @(negedge clk);
        resetn = 1'b1;

        // Single cached load, zero-wait cache
        run_op(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_2000, 0, 0);
        // Two cached slots, zero-wait (serial)
        run_op(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_3000, 32'h0000_3100, 0, 0);
        // Two cached slots, 3-cycle address and data delays
        run_op(0, 1, 1, 0, 0, 3, 3, 3, 3, 32'h0000_4000, 32'h0000_4100, 0, 0);
        // Slot 0 uncached store, slot 1 cached load
        run_op(0, 1, 1, 1, 0, 1, 2, 0, 1, 32'h1FC0_0000, 32'h0000_5000, 1, 0);
        // Slot 0 invalid, slot 1 uncached load
        run_op(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_6000, 32'h1FD0_0010, 0, 0);
        // Back-to-back pair presented in the join cycle
        run_op(1, 1, 1, 0, 1, 0, 1, 2, 0, 32'h0000_7000, 32'h1FE0_0020, 0, 1);
        run_op(1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h1FE0_0040, 32'h0000_8000, 0, 0);

        // Reset while slot 0 is waiting for data
        clear_dreq();
        @(negedge clk);
        cur_addr0 = 32'h0000_9000; cur_addr1 = 32'h0000_9100;
        a_dly0 = 0; d_dly0 = 6; a_dly1 = 0; d_dly1 = 0;
        bus_if.dreq[0] = '{valid: 1'b1, addr: 32'h0000_9000, size: 3'd2, strobe: 4'h0, data: 32'h0};
        bus_if.d_uncache = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_phase0_wait", 64'(dbg_phase[0]), 64'(PH_WAIT));
        chk("mid_dcreq_valid", 64'(bus_if.dcreq.valid), 64'd0);
        @(negedge clk);
        resetn = 1'b0;
        clear_dreq();
        @(posedge clk); #1;
        chk("mrst_dcreq_valid", 64'(bus_if.dcreq.valid), 64'd0);
        chk("mrst_ucreq_valid", 64'(bus_if.ucreq.valid), 64'd0);
        chk("mrst_dresp0", 64'(bus_if.dresp[0]), 64'd0);
        chk("mrst_dresp1", 64'(bus_if.dresp[1]), 64'd0);
        chk("mrst_phase0", 64'(dbg_phase[0]), 64'(PH_IDLE));
        chk("mrst_phase1", 64'(dbg_phase[1]), 64'(PH_IDLE));
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        run_op(0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0000_A000, 32'h0000_A100, 0, 0);

        // Randomized pairs
        for (int k = 0; k < 40; k++) begin
            vv  = $urandom_range(1, 3);
            rv0 = vv[0]; rv1 = vv[1];
            ru0 = 1'($urandom_range(0, 1));
            ru1 = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            ra  = {14'd0, 16'($urandom_range(0, 65535)), 2'b00};
            run_op(rb, rv0, rv1, ru0, ru1,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ra, ra + 32'h0001_0000,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        clear_dreq();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
